// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: width helpers shared by sync_fifo_v2 and fifo_wrap_ptr
//   cnt_w(depth) : bits needed to hold an occupancy of 0..depth
//   ptr_w(depth) : bits needed to index depth entries (at least 1)
package sync_fifo_pkg;
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
    function automatic int ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: modulo-DEPTH pointer, wraps DEPTH-1 -> 0 for any DEPTH
//   clk_i : clock
//   clr_i : synchronous clear to 0 (has priority over inc_i)
//   inc_i : advance pointer by one
//   ptr_o : current pointer value
module fifo_wrap_ptr
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      clk_i,
    input  logic                      clr_i,
    input  logic                      inc_i,
    output logic [ptr_w(DEPTH)-1:0]   ptr_o
);
    localparam int PW = ptr_w(DEPTH);
    logic [PW-1:0] r_ptr;
    always_ff @(posedge clk_i)
        if (clr_i) r_ptr <= '0;
        else if (inc_i) r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    assign ptr_o = r_ptr;
endmodule

// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: single-clock FIFO, any depth, count, almost flags, sticky errors, flush
//   Macro SYNC_FIFO_FWFT_EN: defined -> first-word-fall-through read,
//                            undefined -> registered read (data one cycle after pop)
//   clk_i/rst_i           : clock, synchronous active-high reset
//   clear_i               : synchronous flush
//   push_i/push_data_i    : write request and data
//   pop_i                 : read request (acknowledge in FWFT mode)
//   pop_data_o/pop_valid_o: read data and its qualifier
//   full_o/empty_o        : count == DEPTH / count == 0
//   almost_full_o/_empty_o: count >= AF_THRESH / count <= AE_THRESH
//   count_o               : occupancy
//   overflow_o/underflow_o: sticky refused push / pop on empty
module sync_fifo_v2
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          push_data_i,
    input  logic                      pop_i,
    output logic [WIDTH-1:0]          pop_data_o,
    output logic                      pop_valid_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      almost_full_o,
    output logic                      almost_empty_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o,
    output logic                      overflow_o,
    output logic                      underflow_o
);
    localparam int CW = cnt_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_over;
    logic             r_under;
    logic [PW-1:0]    w_head;
    logic [PW-1:0]    w_tail;
    logic             w_flush;
    logic             w_pop_acc;
    logic             w_push_acc;

    assign w_flush    = rst_i | clear_i;
    assign w_pop_acc  = pop_i & ~empty_o;
    // a push into a full FIFO is still taken when a pop frees a slot the same cycle
    assign w_push_acc = push_i & (~full_o | w_pop_acc);

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_head (
        .clk_i (clk_i),
        .clr_i (w_flush),
        .inc_i (w_pop_acc),
        .ptr_o (w_head)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_tail (
        .clk_i (clk_i),
        .clr_i (w_flush),
        .inc_i (w_push_acc),
        .ptr_o (w_tail)
    );

    always_ff @(posedge clk_i)
        if (w_push_acc & ~w_flush) r_mem[w_tail] <= push_data_i;

    always_ff @(posedge clk_i) begin
        if (w_flush) begin
            r_count <= '0;
            r_over  <= 1'b0;
            r_under <= 1'b0;
        end else begin
            r_count <= r_count + CW'(w_push_acc) - CW'(w_pop_acc);
            r_over  <= r_over | (push_i & ~w_push_acc);
            r_under <= r_under | (pop_i & empty_o);
        end
    end

    // flags decode the count register only, so push_i/pop_i never reach them combinationally
    assign count_o        = r_count;
    assign full_o         = r_count == CW'(DEPTH);
    assign empty_o        = r_count == '0;
    assign almost_full_o  = int'(r_count) >= AF_THRESH;
    assign almost_empty_o = int'(r_count) <= AE_THRESH;
    assign overflow_o     = r_over;
    assign underflow_o    = r_under;

`ifdef SYNC_FIFO_FWFT_EN
    assign pop_valid_o = ~empty_o;
    assign pop_data_o  = empty_o ? '0 : r_mem[w_head];
`else
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    // data holds its last value across flush; only reset zeroes it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (clear_i) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_pop_acc;
            if (w_pop_acc) r_data <= r_mem[w_head];
        end
    end
    assign pop_valid_o = r_valid;
    assign pop_data_o  = r_data;
`endif
endmodule
